// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipelined CPU.
// Holds the datapath width, the NOP bubble encoding and the fetch FSM states.
package pipe_pkg;

    localparam int XLEN = 16;

    // IF/ID loads this on flush; the fetch stage drives it when idle.
    localparam logic [XLEN-1:0] NOP_INSTR = 16'h0003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DROP
    } if_state_t;

endpackage

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: owns the PC and PC+1 adder, issues one-outstanding
// word requests to instruction memory, and feeds the IF/ID register.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   stall_i               hazard stall; holds PC and IF/ID
//   branch_taken_i        redirect request, branch_target_i is the new PC
//   imem_req_o/addr_o     one-cycle request pulse and word address
//   imem_rvalid_i/rdata_i response handshake and instruction
//   PCadder1_sum_o        pc_q+1 to IF/ID
//   Instruction_o         instruction to IF/ID
//   IFIDWrite_o           IF/ID write enable (~stall_i)
//   Flush_o               IF/ID flush, active-low (0 loads NOP)
//   bubble_cnt_o          perf: cycles with Flush_o=0     (IF_PERF_CNT_EN)
//   redirect_cnt_o        perf: cycles with a redirect    (IF_PERF_CNT_EN)
//
// Build option: define IF_PERF_CNT_EN to add the saturating perf counters.
module pipe_if_stage
    import pipe_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_target_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] PCadder1_sum_o,
    output logic [15:0] Instruction_o,
`ifdef IF_PERF_CNT_EN
    output logic [15:0] bubble_cnt_o,
    output logic [15:0] redirect_cnt_o,
`endif
    output logic        IFIDWrite_o,
    output logic        Flush_o
);

    if_state_t       state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] buf_q;
    logic [XLEN-1:0] pc_inc;
    logic            live;
    logic            deliver;
    logic            busy;

    assign pc_inc = pc_q + 16'd1;

    // No redirect and not in reset: the FSM may act this cycle.
    assign live = !rst_i && !branch_taken_i;

    // A request is in flight and has not yet been answered.
    assign busy = (state_q == S_WAIT) || (state_q == S_DROP);

    always_comb begin
        deliver    = 1'b0;
        imem_req_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                imem_req_o = live;
            end
            S_WAIT: begin
                deliver    = live && !stall_i && imem_rvalid_i;
                imem_req_o = deliver;
            end
            S_HOLD: begin
                deliver    = live && !stall_i;
                imem_req_o = deliver;
            end
            S_DROP: begin
                imem_req_o = live && imem_rvalid_i;
            end
            default: begin
                deliver    = 1'b0;
                imem_req_o = 1'b0;
            end
        endcase
    end

    // A delivery fetches the next word in the same cycle.
    assign imem_addr_o = deliver ? pc_inc : pc_q;

    assign PCadder1_sum_o = (rst_i ? RESET_PC : pc_q) + 16'd1;

    always_comb begin
        case (state_q)
            S_WAIT:  Instruction_o = imem_rdata_i;
            S_HOLD:  Instruction_o = buf_q;
            default: Instruction_o = NOP_INSTR;
        endcase
    end

    // Stall keeps flush released so IF/ID's held word survives.
    assign Flush_o     = live && (stall_i || deliver);
    assign IFIDWrite_o = ~stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
            state_q <= S_IDLE;
        end else if (branch_taken_i) begin
            pc_q  <= branch_target_i;
            buf_q <= NOP_INSTR;
            // A response landing with the redirect retires the request.
            if (busy && !imem_rvalid_i)
                state_q <= S_DROP;
            else
                state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (stall_i) begin
                            buf_q   <= imem_rdata_i;
                            state_q <= S_HOLD;
                        end else begin
                            pc_q <= pc_inc;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        pc_q    <= pc_inc;
                        state_q <= S_WAIT;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid_i)
                        state_q <= S_WAIT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    if (1) begin : g_perf
        logic [15:0] bub_q;
        logic [15:0] red_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                bub_q <= 16'h0000;
                red_q <= 16'h0000;
            end else begin
                if (!Flush_o && bub_q != 16'hFFFF)
                    bub_q <= bub_q + 16'd1;
                if (branch_taken_i && red_q != 16'hFFFF)
                    red_q <= red_q + 16'd1;
            end
        end

        assign bubble_cnt_o   = bub_q;
        assign redirect_cnt_o = red_q;
    end
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// Scoreboard bench for pipe_if_stage: directed stimulus pushes expected
// requests/deliveries; a monitor pops and compares at each negedge.
module tb_pipe_if_stage;
    import pipe_pkg::*;

    localparam logic [15:0] RPC = 16'h0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic        rvalid;
    logic [15:0] rdata;
    logic [15:0] sum;
    logic [15:0] instr;
    logic        ifid_we;
    logic        flush_n;
`ifdef IF_PERF_CNT_EN
    logic [15:0] bub;
    logic [15:0] red;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int lat   = 1;
    int pend  = 0;
    logic [15:0] paddr;
    logic        seen;
    logic [15:0] seen_addr;

    logic [15:0] exp_req_q[$];
    logic [31:0] exp_del_q[$];

    always #5 clk = ~clk;

    pipe_if_stage #(
        .RESET_PC (RPC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .branch_taken_i (br),
        .branch_target_i(tgt),
        .imem_req_o     (req),
        .imem_addr_o    (addr),
        .imem_rvalid_i  (rvalid),
        .imem_rdata_i   (rdata),
        .PCadder1_sum_o (sum),
        .Instruction_o  (instr),
`ifdef IF_PERF_CNT_EN
        .bubble_cnt_o   (bub),
        .redirect_cnt_o (red),
`endif
        .IFIDWrite_o    (ifid_we),
        .Flush_o        (flush_n)
    );

    function automatic logic [15:0] memw(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hA001;
            16'h0011: return 16'hA002;
            16'h0012: return 16'hB00B;
            16'h0013: return 16'hC013;
            16'h0040: return 16'hD040;
            16'hFFFF: return 16'hE0FF;
            16'h0000: return 16'hF000;
            16'h0001: return 16'h0101;
            default:  return 16'h7777;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic exp_del(input logic [15:0] i, input logic [15:0] s);
        exp_del_q.push_back({i, s});
    endtask

    // Memory: answers each request after lat cycles.
    initial begin
        rvalid = 1'b0;
        rdata  = 16'h0000;
        paddr  = 16'h0000;
        forever begin
            @(negedge clk);
            seen      = req;
            seen_addr = addr;
            @(posedge clk);
            #1;
            rvalid = 1'b0;
            if (seen) begin
                pend  = lat;
                paddr = seen_addr;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rvalid = 1'b1;
                    rdata  = memw(paddr);
                end
            end
        end
    end

    // Monitor: every request and every delivery must match the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (req === 1'b1) begin
                if (exp_req_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL req_unexpected: got addr %h want none",
                             addr);
                end else begin
                    check("req_addr", addr, exp_req_q.pop_front());
                end
            end
            if (flush_n === 1'b1 && ifid_we === 1'b1) begin
                if (exp_del_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL del_unexpected: got instr %h want none",
                             instr);
                end else begin
                    e = exp_del_q.pop_front();
                    check("del_instr", instr, e[31:16]);
                    check("del_sum", sum, e[15:0]);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        br    = 1'b0;
        tgt   = 16'h0000;

        next();
        mid();
        check("rst_req", 16'(req), 16'h0000);
        check("rst_flush", 16'(flush_n), 16'h0000);
        check("rst_sum", sum, 16'h0011);
        check("rst_instr", instr, NOP_INSTR);

        // c0: first request at RESET_PC
        next();
        rst = 1'b0;
        exp_req_q.push_back(16'h0010);
        mid();
        check("idle_flush", 16'(flush_n), 16'h0000);

        // c1, c2: back-to-back deliveries
        next();
        exp_del(16'hA001, 16'h0011);
        exp_req_q.push_back(16'h0011);
        next();
        exp_del(16'hA002, 16'h0012);
        exp_req_q.push_back(16'h0012);

        // c3..c5: stall as B00B returns
        next();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next();
            mid();
            check("stall_flush", 16'(flush_n), 16'h0001);
            check("stall_we", 16'(ifid_we), 16'h0000);
        end

        // c6: release, held word delivered once
        next();
        stall = 1'b0;
        exp_del(16'hB00B, 16'h0013);
        exp_req_q.push_back(16'h0013);
        mid();
        lat = 3;

        // c7: redirect with request outstanding
        next();
        br  = 1'b1;
        tgt = 16'h0040;
        mid();
        check("br_flush", 16'(flush_n), 16'h0000);

        // c8: waiting for stale response
        next();
        br = 1'b0;
        mid();
        check("drop_flush", 16'(flush_n), 16'h0000);
        check("drop_instr", instr, NOP_INSTR);

        // c9: stale response discarded, request at target
        next();
        exp_req_q.push_back(16'h0040);
        mid();
        check("stale_flush", 16'(flush_n), 16'h0000);
        check("stale_instr", instr, NOP_INSTR);

        // c10..c12: D040 returns under stall
        next();
        next();
        next();
        stall = 1'b1;
        mid();
        check("hold_flush", 16'(flush_n), 16'h0001);

        // c13: branch and stall in HOLD
        next();
        br  = 1'b1;
        tgt = 16'hFFFF;
        mid();
        check("hold_br_flush", 16'(flush_n), 16'h0000);

        // c14: IDLE request at target
        next();
        br    = 1'b0;
        stall = 1'b0;
        exp_req_q.push_back(16'hFFFF);
        mid();
        lat = 1;

        // c15: wrap of PC+1
        next();
        exp_del(16'hE0FF, 16'h0000);
        exp_req_q.push_back(16'h0000);
        mid();
        check("wrap_sum", sum, 16'h0000);
        check("wrap_addr", addr, 16'h0000);

        // c16
        next();
        exp_del(16'hF000, 16'h0001);
        exp_req_q.push_back(16'h0001);
        mid();
        lat = 3;

        // c17, c18: reset mid-WAIT
        next();
        rst = 1'b1;
        mid();
        check("mid_rst_req", 16'(req), 16'h0000);
        check("mid_rst_flush", 16'(flush_n), 16'h0000);
        next();
        mid();
        check("mid_rst_sum", sum, 16'h0011);

        // c19: release; late response must be ignored
        next();
        rst = 1'b0;
        exp_req_q.push_back(16'h0010);
        mid();
        check("late_flush", 16'(flush_n), 16'h0000);
        check("late_instr", instr, NOP_INSTR);

        // c20..c22
        next();
        next();
        next();
        exp_del(16'hA001, 16'h0011);
        exp_req_q.push_back(16'h0011);

        // c23: quiesce
        next();
        rst = 1'b1;

`ifdef IF_PERF_CNT_EN
        next();
        mid();
        check("perf_rst_bub", bub, 16'h0000);
        check("perf_rst_red", red, 16'h0000);
        next();
        rst = 1'b0;
        br  = 1'b1;
        tgt = 16'h0100;
        next();
        next();
        next();
        mid();
        check("perf_bub3", bub, 16'h0003);
        check("perf_red3", red, 16'h0003);
        repeat (65540) next();
        mid();
        check("perf_bub_sat", bub, 16'hFFFF);
        check("perf_red_sat", red, 16'hFFFF);
        next();
        br  = 1'b0;
        rst = 1'b1;
`endif

        next();
        mid();
        check("req_q_left", 16'(exp_req_q.size()), 16'h0000);
        check("del_q_left", 16'(exp_del_q.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined CPU; sits directly upstream of the IF/ID pipeline register and feeds it.
- Owns the PC register and the PC+1 adder.
- Issues one-outstanding word-addressed requests to instruction memory.
- Handles hazard-unit stalls and branch redirects.
- Drives IF/ID's write enable and its active-low flush, which inserts a NOP bubble.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0003, bubble encoding (must match IF/ID flush value)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
stall_i  in  1  hazard-unit stall; 1 = hold PC and IF/ID
branch_taken_i  in  1  redirect request from EX/ID
branch_target_i  in  16  redirect PC
imem_req_o  out  1  one-cycle request pulse
imem_addr_o  out  16  request word address
imem_rvalid_i  in  1  response valid (exactly one per request, ≥1 cycle after request)
imem_rdata_i  in  16  response instruction
PCadder1_sum_o  out  16  pc_q+1 to IF/ID
Instruction_o  out  16  instruction to IF/ID
IFIDWrite_o  out  1  IF/ID write enable = ~stall_i
Flush_o  out  1  IF/ID flush, active-low (0 = load NOP)

Behaviour:
- Registers: pc_q, buf_q (16b), state.
- States: S_IDLE, S_WAIT, S_HOLD, S_DROP.
- Reset values: pc_q=RESET_PC, state=S_IDLE, buf_q=NOP_INSTR.
- Reset is synchronous; it aborts any outstanding request. A response arriving after reset is ignored in S_IDLE.
- Outputs:
  - PCadder1_sum_o = pc_q+1, modulo 2^16 (16'hFFFF+1 = 16'h0000). During reset this equals RESET_PC+1.
  - Instruction_o = imem_rdata_i in S_WAIT, buf_q in S_HOLD, NOP_INSTR otherwise.
  - imem_req_o and Flush_o are 0 during reset.
- Flush_o rule:
  - 0 whenever branch_taken_i=1.
  - Otherwise 0 when no valid instruction is being delivered and stall_i=0.
  - Forced to 1 whenever stall_i=1 and no branch. Flush overrides hold in IF/ID, so the held instruction must not be destroyed.
- Priority: branch_taken_i > stall_i > delivery.
- S_IDLE:
  - Branch: pc_q<=target; stay.
  - Otherwise: imem_req_o=1, imem_addr_o=pc_q; go to S_WAIT.
- S_WAIT:
  - Branch with rvalid: discard response; pc_q<=target; go to S_IDLE.
  - Branch without rvalid: pc_q<=target; go to S_DROP.
  - rvalid and !stall_i: deliver (Flush_o=1); pc_q<=pc_q+1; issue request at pc_q+1 the same cycle; stay in S_WAIT. Back-to-back throughput is 1 instruction per memory latency.
  - rvalid and stall_i: buf_q<=rdata; go to S_HOLD.
  - No rvalid: bubble.
- S_HOLD:
  - Branch: pc_q<=target; drop buf_q; go to S_IDLE.
  - !stall_i: deliver buf_q (Flush_o=1); pc_q<=pc_q+1; issue request at pc_q+1; go to S_WAIT.
  - Otherwise: hold.
- S_DROP:
  - Branch: pc_q<=target; stay.
  - rvalid: discard; issue request at pc_q; go to S_WAIT.
  - Flush_o=0 unless stall_i=1.
- imem_addr_o is don't-care when imem_req_o=0; drive pc_q.
- Never more than one request outstanding.
- A response is never delivered on a redirect cycle.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined: adds outputs bubble_cnt_o[15:0] and redirect_cnt_o[15:0].
  - bubble_cnt_o increments each cycle Flush_o=0 with rst_i=0.
  - redirect_cnt_o increments each cycle branch_taken_i=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - XLEN=16
  - NOP_INSTR value 16'h0003
  - if_state_t enum {S_IDLE, S_WAIT, S_HOLD, S_DROP}
- The IF/ID register and this block both take the NOP encoding from the package.
- No sub-module; the adder and FSM stay inline.
- Perf counters form one generate block under the macro.

Test Plan:
- Reset with RESET_PC=16'h0010, then release; 1-cycle memory latency returning 16'hA001, 16'hA002 → requests at 0x0010, then 0x0011 and 0x0012 issued on delivery cycles; Instruction_o/Flush_o=1 on those cycles; PCadder1_sum_o 0x0011, then 0x0012.
- stall_i=1 for 3 cycles exactly when rvalid returns 16'hB00B → S_HOLD; Flush_o=1 and IFIDWrite_o=0 throughout; on release 16'hB00B delivered once; next request at pc+1.
- branch_taken_i with target 0x0040 while a request is outstanding (3-cycle latency) → Flush_o=0 that cycle; stale response discarded; next request at 0x0040; no stale instruction reaches Instruction_o.
- branch_taken_i and stall_i both 1 in S_HOLD → Flush_o=0, buf dropped, pc_q=target, then S_IDLE request at target.
- pc_q=16'hFFFF delivery → PCadder1_sum_o=16'h0000; next request address 0x0000.
- Assert rst_i mid-S_WAIT, with the response arriving the cycle after release → response ignored; first request at RESET_PC. With IF_PERF_CNT_EN, counters read 0 after reset and saturate at 16'hFFFF under forced stall-free bubbles.
